// File: rtl/nor_chk_pkg.sv
// Shared types and helpers for the 2-input gate stimulus/response checkers.
// A checker for another 2-input gate reuses this package with its own expected-value function.
package nor_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int               VEC_W    = 2;
  localparam logic [VEC_W-1:0] LAST_VEC = 2'b11;

  // Expected output of the cell under test for input vector {a,b}.
  function automatic logic nor_exp(input logic [VEC_W-1:0] vec);
    return ~|vec;
  endfunction

endpackage

// File: rtl/nor_gate_checker.sv
// Drives all four {a,b} combinations into a 2-input NOR cell, samples y after a
// programmable settle time and reports pass/fail, a saturating error count and the first failing vector.
module nor_gate_checker
  import nor_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 dut_a,
  output logic                 dut_b,
  input  logic                 dut_y,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [VEC_W-1:0]     first_fail,
  output logic                 first_fail_vld
);

  if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 255)) begin : g_bad_settle
    $error("nor_gate_checker: SETTLE_CYCLES must be in 1..255");
  end

  localparam logic [7:0]           SETTLE_INIT = 8'(SETTLE_CYCLES - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_ZERO    = {ERR_CNT_W{1'b0}};
  localparam logic [ERR_CNT_W-1:0] ERR_ONE     = ERR_CNT_W'(1);

  state_e               state_r,          state_nxt_s;
  logic [VEC_W-1:0]     vec_r,            vec_nxt_s;
  logic [7:0]           settle_cnt_r,     settle_cnt_nxt_s;
  logic                 busy_r,           busy_nxt_s;
  logic                 done_r,           done_nxt_s;
  logic                 pass_r,           pass_nxt_s;
  logic [ERR_CNT_W-1:0] err_cnt_r,        err_cnt_nxt_s;
  logic [VEC_W-1:0]     first_fail_r,     first_fail_nxt_s;
  logic                 first_fail_vld_r, first_fail_vld_nxt_s;
  logic                 mismatch_s;
  logic                 err_sat_s;

  // Case inequality so an X or Z on the cell output counts as a failure in simulation.
  assign mismatch_s = (dut_y !== nor_exp(vec_r));
  assign err_sat_s  = &err_cnt_r;

  // State and result registers; reset clears any partial sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r          <= IDLE;
      vec_r            <= {VEC_W{1'b0}};
      settle_cnt_r     <= 8'd0;
      busy_r           <= 1'b0;
      done_r           <= 1'b0;
      pass_r           <= 1'b0;
      err_cnt_r        <= ERR_ZERO;
      first_fail_r     <= {VEC_W{1'b0}};
      first_fail_vld_r <= 1'b0;
    end else begin
      state_r          <= state_nxt_s;
      vec_r            <= vec_nxt_s;
      settle_cnt_r     <= settle_cnt_nxt_s;
      busy_r           <= busy_nxt_s;
      done_r           <= done_nxt_s;
      pass_r           <= pass_nxt_s;
      err_cnt_r        <= err_cnt_nxt_s;
      first_fail_r     <= first_fail_nxt_s;
      first_fail_vld_r <= first_fail_vld_nxt_s;
    end
  end

  // Next-state and next-result logic; busy/done/pass are computed one cycle ahead so they come straight from flops.
  always_comb begin
    state_nxt_s          = state_r;
    vec_nxt_s            = vec_r;
    settle_cnt_nxt_s     = settle_cnt_r;
    busy_nxt_s           = busy_r;
    done_nxt_s           = 1'b0;
    pass_nxt_s           = pass_r;
    err_cnt_nxt_s        = err_cnt_r;
    first_fail_nxt_s     = first_fail_r;
    first_fail_vld_nxt_s = first_fail_vld_r;

    case (state_r)
      IDLE: begin
        if (start) begin
          vec_nxt_s            = {VEC_W{1'b0}};
          settle_cnt_nxt_s     = SETTLE_INIT;
          err_cnt_nxt_s        = ERR_ZERO;
          first_fail_nxt_s     = {VEC_W{1'b0}};
          first_fail_vld_nxt_s = 1'b0;
          pass_nxt_s           = 1'b0;
          busy_nxt_s           = 1'b1;
          state_nxt_s          = SETTLE;
        end else begin
          state_nxt_s = IDLE;
        end
      end

      SETTLE: begin
        if (settle_cnt_r == 8'd0) begin
          state_nxt_s = CHECK;
        end else begin
          settle_cnt_nxt_s = settle_cnt_r - 8'd1;
        end
      end

      CHECK: begin
        if (mismatch_s) begin
          if (!err_sat_s) begin
            err_cnt_nxt_s = err_cnt_r + ERR_ONE;
          end else begin
            err_cnt_nxt_s = err_cnt_r;
          end
          if (!first_fail_vld_r) begin
            first_fail_nxt_s     = vec_r;
            first_fail_vld_nxt_s = 1'b1;
          end else begin
            first_fail_nxt_s     = first_fail_r;
          end
        end else begin
          err_cnt_nxt_s = err_cnt_r;
        end

        if (vec_r == LAST_VEC) begin
          // The DONE cycle sees done=1, busy=0 and the final verdict.
          busy_nxt_s  = 1'b0;
          done_nxt_s  = 1'b1;
          pass_nxt_s  = (err_cnt_nxt_s == ERR_ZERO);
          state_nxt_s = DONE;
        end else begin
          vec_nxt_s        = vec_r + 2'd1;
          settle_cnt_nxt_s = SETTLE_INIT;
          state_nxt_s      = SETTLE;
        end
      end

      DONE: begin
        state_nxt_s = IDLE;
      end

      default: begin
        state_nxt_s = IDLE;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  assign dut_a          = vec_r[1];
  assign dut_b          = vec_r[0];
  assign busy           = busy_r;
  assign done           = done_r;
  assign pass           = pass_r;
  assign err_count      = err_cnt_r;
  assign first_fail     = first_fail_r;
  assign first_fail_vld = first_fail_vld_r;

endmodule

// File: tb/tb_nor_gate_checker.sv
// Self-checking bench: a NOR cell model with injectable faults, table-driven and random sweeps,
// plus hand-written start-drop, reset-abort, saturation and short-settle sequences.
module tb_nor_gate_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, start_w1, start_s1;
  int   vectors = 0;
  int   miscompares = 0;

  // Main instance: default parameters, cell with flip mask and open pull-down fault.
  logic       dut_a, dut_b, dut_y, busy, done, pass, first_fail_vld, nor_y, y_hold, open_n2;
  logic [3:0] err_count, mask;
  logic [1:0] first_fail;

  // Secondary instances: 1-bit error counter with an OR cell; settle of 1 with a good NOR cell.
  logic       a_w1, b_w1, y_w1, busy_w1, done_w1, pass_w1, vld_w1;
  logic [0:0] err_w1;
  logic [1:0] ff_w1;
  logic       a_s1, b_s1, y_s1, busy_s1, done_s1, pass_s1, vld_s1;
  logic [3:0] err_s1;
  logic [1:0] ff_s1;

  // The open-n2 fault leaves y floating at ab=01, where the node keeps its previous charge.
  assign nor_y = ~(dut_a | dut_b) ^ mask[{dut_a, dut_b}];
  assign dut_y = (open_n2 && !dut_a && dut_b) ? y_hold : nor_y;
  always @(posedge clk) y_hold <= dut_y;
  assign y_w1 = a_w1 | b_w1;
  assign y_s1 = ~(a_s1 | b_s1);

  nor_gate_checker #(.SETTLE_CYCLES(2), .ERR_CNT_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_a(dut_a), .dut_b(dut_b), .dut_y(dut_y),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail(first_fail), .first_fail_vld(first_fail_vld));

  nor_gate_checker #(.SETTLE_CYCLES(2), .ERR_CNT_W(1)) u_dut_w1 (
    .clk(clk), .rst_n(rst_n), .start(start_w1), .dut_a(a_w1), .dut_b(b_w1), .dut_y(y_w1),
    .busy(busy_w1), .done(done_w1), .pass(pass_w1), .err_count(err_w1),
    .first_fail(ff_w1), .first_fail_vld(vld_w1));

  nor_gate_checker #(.SETTLE_CYCLES(1), .ERR_CNT_W(4)) u_dut_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_s1), .dut_a(a_s1), .dut_b(b_s1), .dut_y(y_s1),
    .busy(busy_s1), .done(done_s1), .pass(pass_s1), .err_count(err_s1),
    .first_fail(ff_s1), .first_fail_vld(vld_s1));

  typedef struct {
    logic [3:0] mask;
    int         err;
    int         ff;
    int         vld;
    int         pss;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: every flipped vector is one error (saturating), the lowest flipped one is first_fail.
  function automatic void ref_model(input logic [3:0] m, input int maxc,
                                    output int err, output int ff, output int vld, output int pss);
    err = 0; ff = 0; vld = 0;
    for (int v = 0; v < 4; v++) begin
      if (m[v]) begin
        if (err < maxc) err++;
        if (vld == 0) begin ff = v; vld = 1; end
      end
    end
    pss = (err == 0) ? 1 : 0;
  endfunction

  // One sweep on the main instance; cycle k is observed at the negedge after the k-th edge past the start-sampling edge.
  task automatic sweep(input int rp1, input int rp2, input bit walk,
                       output int done_k, output int done_n, output int busy_n);
    done_k = 0; done_n = 0; busy_n = 0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      start = (k == rp1) || (k == rp2);
      if (k == 1) begin
        check("clr_pass", pass, 0);
        check("clr_err", err_count, 0);
        check("clr_vld", first_fail_vld, 0);
      end
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_k == 0) done_k = k;
      end
      if (walk && k <= 14) check("walk", {dut_a, dut_b}, (k > 12) ? 3 : (k - 1) / 3);
    end
    start = 1'b0;
  endtask

  int dk, dn, bn, e_err, e_ff, e_vld, e_pss, dk_w1, dk_s1, bn_s1;

  initial begin
    rst_n = 1'b0; start = 1'b0; start_w1 = 1'b0; start_s1 = 1'b0; mask = 4'b0000; open_n2 = 1'b0;
    tbl[0] = '{4'b0000, 0, 0, 0, 1};
    tbl[1] = '{4'b0010, 1, 1, 1, 0};
    tbl[2] = '{4'b1111, 4, 0, 1, 0};
    tbl[3] = '{4'b1000, 1, 3, 1, 0};
    tbl[4] = '{4'b1100, 2, 2, 1, 0};
    tbl[5] = '{4'b0101, 2, 0, 1, 0};

    repeat (2) @(negedge clk);
    check("rst_a", dut_a, 0);
    check("rst_b", dut_b, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    check("rst_ff", first_fail, 0);
    check("rst_vld", first_fail_vld, 0);
    rst_n = 1'b1;

    // Table entry 0 also re-pulses start in SETTLE of vector 1 and in the DONE cycle.
    for (int i = 0; i < 6; i++) begin
      mask = tbl[i].mask;
      sweep((i == 0) ? 5 : 0, (i == 0) ? 13 : 0, (i == 0), dk, dn, bn);
      check("done_cycle", dk, 13);
      check("done_pulses", dn, 1);
      check("busy_cycles", bn, 12);
      check("tbl_err", err_count, tbl[i].err);
      check("tbl_ff", first_fail, tbl[i].ff);
      check("tbl_vld", first_fail_vld, tbl[i].vld);
      check("tbl_pass", pass, tbl[i].pss);
      check("idle_pins", {dut_a, dut_b}, 3);
    end

    mask = 4'b0000;
    open_n2 = 1'b1;
    sweep(0, 0, 1'b0, dk, dn, bn);
    check("open_err", err_count, 1);
    check("open_ff", first_fail, 1);
    check("open_vld", first_fail_vld, 1);
    check("open_pass", pass, 0);
    open_n2 = 1'b0;

    for (int r = 0; r < 8; r++) begin
      mask = 4'($urandom_range(0, 15));
      repeat ($urandom_range(0, 4)) @(negedge clk);
      ref_model(mask, 15, e_err, e_ff, e_vld, e_pss);
      sweep(0, 0, 1'b0, dk, dn, bn);
      check("rnd_done", dk, 13);
      check("rnd_err", err_count, e_err);
      check("rnd_ff", first_fail, e_ff);
      check("rnd_vld", first_fail_vld, e_vld);
      check("rnd_pass", pass, e_pss);
    end

    // Abort in CHECK of vector 2 after vector 0 has already failed.
    mask = 4'b0001;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    check("pre_rst_a", dut_a, 1);
    check("pre_rst_err", err_count, 1);
    rst_n = 1'b0;
    #1;
    check("abort_a", dut_a, 0);
    check("abort_busy", busy, 0);
    check("abort_err", err_count, 0);
    check("abort_vld", first_fail_vld, 0);
    check("abort_ff", first_fail, 0);
    check("abort_pass", pass, 0);
    @(negedge clk); rst_n = 1'b1;
    mask = 4'b0000;
    sweep(0, 0, 1'b1, dk, dn, bn);
    check("post_done", dk, 13);
    check("post_err", err_count, 0);
    check("post_pass", pass, 1);

    dk_w1 = 0; dk_s1 = 0; bn_s1 = 0;
    @(negedge clk); start_w1 = 1'b1; start_s1 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start_w1 = 1'b0; start_s1 = 1'b0;
      if (busy_s1) bn_s1++;
      if (done_s1 && dk_s1 == 0) dk_s1 = k;
      if (done_w1 && dk_w1 == 0) dk_w1 = k;
    end
    check("s1_busy", bn_s1, 8);
    check("s1_done", dk_s1, 9);
    check("s1_pass", pass_s1, 1);
    check("s1_err", err_s1, 0);
    check("w1_done", dk_w1, 13);
    check("w1_err_sat", err_w1, 1);
    check("w1_ff", ff_w1, 0);
    check("w1_vld", vld_w1, 1);
    check("w1_pass", pass_w1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
